// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the synchronous FIFO family
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Contents are deliberately never reset so this maps onto distributed RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock FIFO, standard or show-ahead read; FIFO_ERR_FLAGS_EN adds sticky error flags
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH  = 128,
  parameter int  DEPTH       = 16,
  parameter int  ALMOST_MTY  = 1,
  parameter int  ALMOST_FULL = 1,
  parameter int  SHOWAHEAD   = 0,
  localparam int ADDR_W      = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  almost_full,
  output logic                  mty,
  output logic                  almost_mty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AFULL = (ADDR_W+1)'(DEPTH - ALMOST_FULL);
  localparam logic [ADDR_W:0] CNT_AMTY  = (ADDR_W+1)'(ALMOST_MTY);

  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_ok;
  logic                  w_wr_ok;

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign w_rd_ok = rd & ~mty;
  assign w_wr_ok = wr & (~full | w_rd_ok);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_wr_ok),
    .i_waddr(r_wr_ptr),
    .i_wdata(data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );

  generate
    if (SHOWAHEAD == FIFO_MODE_FWFT) begin : g_fwft
      assign q = w_rd_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_q;
      always_ff @(posedge clk) begin
        if (srst)         r_q <= '0;
        else if (w_rd_ok) r_q <= w_rd_data;
      end
      assign q = r_q;
    end
  endgenerate

  assign count       = r_count;
  assign mty         = (r_count == '0);
  assign full        = (r_count == CNT_FULL);
  assign almost_full = (r_count >= CNT_AFULL);
  assign almost_mty  = (r_count <= CNT_AMTY);

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & ~w_wr_ok) r_overflow  <= 1'b1;
      if (rd & mty)      r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - self-checking bench: standard and show-ahead instances against a queue model
module tb_fifo_sync_fwft;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int A_AM  = 1;
  localparam int A_AF  = 1;
  localparam int B_AM  = 3;
  localparam int B_AF  = 4;

  logic          clk  = 1'b0;
  logic          srst = 1'b1;
  logic          wr   = 1'b0;
  logic          rd   = 1'b0;
  logic [DW-1:0] data = '0;

  logic [DW-1:0] a_q, b_q;
  logic          a_full, a_afull, a_mty, a_amty, a_ov, a_un;
  logic          b_full, b_afull, b_mty, b_amty, b_ov, b_un;
  logic [AW:0]   a_count, b_count;

  fifo_sync_fwft #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_MTY(A_AM), .ALMOST_FULL(A_AF), .SHOWAHEAD(0)
  ) u_std (
    .clk(clk), .srst(srst), .wr(wr), .data(data), .rd(rd), .q(a_q),
    .full(a_full), .almost_full(a_afull), .mty(a_mty), .almost_mty(a_amty),
    .count(a_count), .overflow(a_ov), .underflow(a_un)
  );

  fifo_sync_fwft #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_MTY(B_AM), .ALMOST_FULL(B_AF), .SHOWAHEAD(1)
  ) u_fwft (
    .clk(clk), .srst(srst), .wr(wr), .data(data), .rd(rd), .q(b_q),
    .full(b_full), .almost_full(b_afull), .mty(b_mty), .almost_mty(b_amty),
    .count(b_count), .overflow(b_ov), .underflow(b_un)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of stored words plus the standard-mode output register.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q_std = '0;
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;

  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] data;
    int            e_count;
    bit            e_full;
    bit            e_afull;
    bit            e_mty;
    logic [DW-1:0] e_q;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit w, input bit r, input logic [DW-1:0] d);
    bit rd_ok, wr_ok;
    if (s) begin
      mq.delete();
      m_q_std = '0;
      m_ov    = 1'b0;
      m_un    = 1'b0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
      if (w && !wr_ok) m_ov = 1'b1;
      if (r && mq.size() == 0) m_un = 1'b1;
      if (rd_ok) m_q_std = mq.pop_front();
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    bit e_ov, e_un;
    n = mq.size();
`ifdef FIFO_ERR_FLAGS_EN
    e_ov = m_ov;
    e_un = m_un;
`else
    e_ov = 1'b0;
    e_un = 1'b0;
`endif
    chk("std_count",  32'(a_count), 32'(n));
    chk("std_mty",    32'(a_mty),   32'(n == 0));
    chk("std_full",   32'(a_full),  32'(n == DEPTH));
    chk("std_afull",  32'(a_afull), 32'(n >= DEPTH - A_AF));
    chk("std_amty",   32'(a_amty),  32'(n <= A_AM));
    chk("std_q",      a_q,          m_q_std);
    chk("std_ovf",    32'(a_ov),    32'(e_ov));
    chk("std_unf",    32'(a_un),    32'(e_un));
    chk("fwft_count", 32'(b_count), 32'(n));
    chk("fwft_mty",   32'(b_mty),   32'(n == 0));
    chk("fwft_full",  32'(b_full),  32'(n == DEPTH));
    chk("fwft_afull", 32'(b_afull), 32'(n >= DEPTH - B_AF));
    chk("fwft_amty",  32'(b_amty),  32'(n <= B_AM));
    chk("fwft_ovf",   32'(b_ov),    32'(e_ov));
    chk("fwft_unf",   32'(b_un),    32'(e_un));
    if (n > 0) chk("fwft_q", b_q, mq[0]);
  endtask

  task automatic cycle(input bit s, input bit w, input bit r, input logic [DW-1:0] d);
    srst = s;
    wr   = w;
    rd   = r;
    data = d;
    @(posedge clk);
    model_step(s, w, r, d);
    #1;
    check_model();
  endtask

  task automatic add(input bit w, input bit r, input logic [DW-1:0] d, input int c,
                     input bit f, input bit af, input bit m, input logic [DW-1:0] eq);
    vec_t v;
    v.wr = w; v.rd = r; v.data = d; v.e_count = c;
    v.e_full = f; v.e_afull = af; v.e_mty = m; v.e_q = eq;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 1; i <= 16; i++) add(1, 0, DW'(i), i, i == 16, i >= 15, 0, '0);
    add(1, 0, 'hFF, 16, 1, 1, 0, '0);
    for (int k = 1; k <= 16; k++) add(0, 1, '0, 16 - k, 0, (16 - k) >= 15, k == 16, DW'(k));
    add(0, 1, '0, 0, 0, 0, 1, 'h10);
    for (int i = 1; i <= 16; i++) add(1, 0, DW'('h100 + i), i, i == 16, i >= 15, 0, 'h10);
    add(1, 1, 'hAA, 16, 1, 1, 0, 'h101);
    for (int k = 1; k <= 16; k++)
      add(0, 1, '0, 16 - k, 0, (16 - k) >= 15, k == 16, (k < 16) ? DW'('h101 + k) : DW'('hAA));
    add(1, 1, 'h33, 1, 0, 0, 0, 'hAA);
    add(0, 1, '0, 0, 0, 0, 1, 'h33);

    repeat (3) cycle(1, 0, 0, '0);
    chk("rst_count", 32'(a_count), 32'(0));
    chk("rst_q",     a_q,          '0);

    foreach (vecs[i]) begin
      cycle(0, vecs[i].wr, vecs[i].rd, vecs[i].data);
      chk("vec_count", 32'(a_count), 32'(vecs[i].e_count));
      chk("vec_full",  32'(a_full),  32'(vecs[i].e_full));
      chk("vec_afull", 32'(a_afull), 32'(vecs[i].e_afull));
      chk("vec_mty",   32'(a_mty),   32'(vecs[i].e_mty));
      chk("vec_q",     a_q,          vecs[i].e_q);
    end

    // Show-ahead head word appears without any read request.
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, 'h5A);
    chk("sa_mty", 32'(b_mty), 32'(0));
    chk("sa_q",   b_q,        'h5A);
    cycle(0, 0, 0, '0);
    chk("sa_hold", b_q, 'h5A);
    cycle(0, 0, 1, '0);
    chk("sa_pop_mty",   32'(b_mty),   32'(1));
    chk("sa_pop_count", 32'(b_count), 32'(0));

    for (int i = 0; i < 5; i++) cycle(0, 1, i == 4, DW'('h200 + i));
    cycle(1, 1, 1, 'h77);
    chk("srst_count", 32'(a_count), 32'(0));
    chk("srst_q",     a_q,          '0);

    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 500; c++) begin
        cycle($urandom_range(0, 999) == 0,
              $urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 30),
              $urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 80),
              $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
